// File: rtl/inst_rom_loader_pkg.sv
// Shared constants for the instruction ROM loader: bus widths, default depth, loader states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_rom_loader_pkg;

  // Default word-address width of the instruction memory (1024 words).
  localparam int InstMemNumLog2 = 10;

  // Instruction and instruction-address bus widths.
  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;

  // All-zero word; decodes as a nop in the core.
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  // Loader state encodings.
  localparam logic [1:0] LdIdle = 2'd0;
  localparam logic [1:0] LdLoad = 2'd1;
  localparam logic [1:0] LdRun  = 2'd2;

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from raddr_i.
// Backpressure: none; a write is taken every cycle we_i is high.
module inst_mem_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = InstMemNumLog2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [InstBus-1:0]    wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [InstBus-1:0]    rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Contents are never reset so a program survives a system reset.
  logic [InstBus-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, written by a valid/ready program-load stream.
// Latency: fetch is combinational; a loaded word is readable the cycle after it is accepted.
// Backpressure: load_ready_o is high only while loading; the sender may stall valid freely.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = InstMemNumLog2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_data_o,
  input  logic                   load_start_i,
  input  logic [ADDR_WIDTH:0]    load_len_i,
  input  logic                   load_valid_i,
  input  logic [InstBus-1:0]     load_data_i,
  output logic                   load_ready_o,
  output logic                   load_done_o,
  output logic                   core_rst_o,
  output logic                   err_o
);

  // Lengths and counters carry one extra bit so DEPTH itself is representable.
  localparam logic [ADDR_WIDTH:0] DepthLen = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LenOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  logic                done_q, done_d;
  logic                core_rst_q, core_rst_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [InstBus-1:0]  mem_rdata;
  logic                addr_legal;

  // Word-aligned and inside the memory window; anything else returns a nop.
  assign addr_legal = (rom_addr_i[1:0] == 2'b00) &&
                      ((rom_addr_i >> (ADDR_WIDTH + 2)) == '0);

  // Next-state logic: load sequencing, completion pulse and sticky error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      LdLoad: begin
        // A start request here is ignored; the current load runs to completion.
        if (load_valid_i) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + LenOne;
          if (cnt_q == len_q - LenOne) begin
            state_d = LdRun;
            done_d  = 1'b1;
          end
        end
      end
      LdIdle, LdRun: begin
        if (load_start_i) begin
          err_d = 1'b0;
          if (load_len_i == '0) begin
            state_d = LdRun;
          end else begin
            state_d = LdLoad;
            cnt_d   = '0;
            len_d   = (load_len_i > DepthLen) ? DepthLen : load_len_i;
          end
          // Oversized request is clamped but flagged; set wins over the clear above.
          if (load_len_i > DepthLen) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = LdIdle;
    endcase

    if ((state_q == LdRun) && rom_ce_i && !addr_legal) begin
      err_d = 1'b1;
    end

    // Core is held in reset whenever the next state has no complete program.
    core_rst_d = (state_d != LdRun);

    // A word presented on a reset edge is dropped along with the load.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // State registers with synchronous reset; memory contents are not touched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LdIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
    end
  end

  inst_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cnt_q[ADDR_WIDTH-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (rom_addr_i[ADDR_WIDTH+1:2]),
    .rdata_o (mem_rdata)
  );

  assign load_ready_o = (state_q == LdLoad);
  assign rom_data_o   = ((state_q == LdRun) && rom_ce_i && addr_legal) ? mem_rdata : ZeroWord;
  assign load_done_o  = done_q;
  assign core_rst_o   = core_rst_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: directed loads and fetches with hand-computed results.
// Latency: checks sample outputs on the falling edge of the cycle they are issued in.
// Backpressure: load words are offered only while the loader is expected to be ready.
module tb_inst_rom_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_i;
  logic [31:0]   rom_addr_i;
  logic [31:0]   rom_data_o;
  logic          load_start_i;
  logic [AW:0]   load_len_i;
  logic          load_valid_i;
  logic [31:0]   load_data_i;
  logic          load_ready_o;
  logic          load_done_o;
  logic          core_rst_o;
  logic          err_o;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        crst;
    logic        err;
    logic        rdy;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_q[$];
  exp_t        mon_e;
  int unsigned done_exp;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned acc_total = 0;
  logic        chk_vld = 1'b0;
  logic        fin_vld = 1'b0;
  logic        mon_end = 1'b0;

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .core_rst_o   (core_rst_o),
    .err_o        (err_o)
  );

  initial forever #5 clk = ~clk;

  // Count every accepted load word so completion pulses can be checked against it.
  always @(posedge clk) begin
    if (!rst && load_valid_i && load_ready_o) acc_total <= acc_total + 1;
  end

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pops expectations when a check is presented or a done pulse appears.
  initial forever begin
    @(negedge clk);
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        cmp("scoreboard", "underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        cmp(mon_e.name, "rom_data", rom_data_o, mon_e.data);
        cmp(mon_e.name, "core_rst", {31'd0, core_rst_o}, {31'd0, mon_e.crst});
        cmp(mon_e.name, "err", {31'd0, err_o}, {31'd0, mon_e.err});
        cmp(mon_e.name, "ready", {31'd0, load_ready_o}, {31'd0, mon_e.rdy});
        cmp(mon_e.name, "done", {31'd0, load_done_o}, {31'd0, mon_e.done});
      end
    end
    if (load_done_o) begin
      if (done_q.size() == 0) begin
        cmp("done_pulse", "unexpected", 32'd1, 32'd0);
      end else begin
        done_exp = done_q.pop_front();
        cmp("done_pulse", "words_accepted", acc_total, done_exp);
      end
    end
    if (fin_vld && !mon_end) begin
      cmp("end", "checks_left", exp_q.size(), 32'd0);
      cmp("end", "done_pulses_missing", done_q.size(), 32'd0);
      mon_end = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch for one cycle and queue the expected outputs for that cycle.
  task automatic chk(input string nm, input logic ce, input logic [31:0] addr, input logic [31:0] d,
                     input logic crst, input logic err, input logic rdy, input logic done);
    exp_t e;
    rom_ce_i   = ce;
    rom_addr_i = addr;
    e.name = nm; e.data = d; e.crst = crst; e.err = err; e.rdy = rdy; e.done = done;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    tick();
    chk_vld  = 1'b0;
    rom_ce_i = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len);
    load_start_i = 1'b1;
    load_len_i   = len;
    tick();
    load_start_i = 1'b0;
    load_len_i   = '0;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    repeat (gap) tick();
    load_data_i  = w;
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0;
    load_start_i = 1'b0; load_len_i = '0; load_valid_i = 1'b0; load_data_i = '0;
    tick(); tick();
    chk("reset_fetch0", 1, 32'h0, 32'h0, 1, 0, 0, 0);
    rst = 1'b0;
    tick();

    // Four-word program with gaps on valid.
    done_q.push_back(acc_total + 4);
    start(11'd4);
    chk("load4_busy", 1, 32'h0, 32'h0, 1, 0, 1, 0);
    send(32'h20010001, 0);
    send(32'h20020002, 1);
    send(32'h00221820, 2);
    send(32'h00000000, 1);
    chk("load4_first_fetch", 1, 32'h0, 32'h20010001, 0, 0, 0, 1);
    chk("load4_w2", 1, 32'h8, 32'h00221820, 0, 0, 0, 0);
    chk("load4_w1", 1, 32'h4, 32'h20020002, 0, 0, 0, 0);
    chk("ce_low", 0, 32'h4, 32'h0, 0, 0, 0, 0);

    // Illegal fetches set err on their edge; a start clears it.
    chk("misaligned", 1, 32'h2, 32'h0, 0, 0, 0, 0);
    chk("err_set_misaligned", 1, 32'h0, 32'h20010001, 0, 1, 0, 0);
    start(11'd0);
    chk("err_cleared", 1, 32'h0, 32'h20010001, 0, 0, 0, 0);
    chk("out_of_range", 1, 32'h1000, 32'h0, 0, 0, 0, 0);
    chk("err_set_range", 1, 32'h4, 32'h20020002, 0, 1, 0, 0);

    // Reset part-way through a load; memory keeps what was written.
    start(11'd3);
    send(32'hAAAA0001, 0);
    send(32'hAAAA0002, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_load", 1, 32'h0, 32'h0, 1, 0, 0, 0);
    start(11'd0);
    chk("reload0_w0", 1, 32'h0, 32'hAAAA0001, 0, 0, 0, 0);
    chk("reload0_w1", 1, 32'h4, 32'hAAAA0002, 0, 0, 0, 0);
    chk("reload0_w2_kept", 1, 32'h8, 32'h00221820, 0, 0, 0, 0);

    // Oversized length is clamped to the full depth and flagged.
    done_q.push_back(acc_total + 1024);
    start(11'd1025);
    chk("oversize_err", 1, 32'h0, 32'h0, 1, 1, 1, 0);
    for (int i = 0; i < 1024; i++) send(32'h5A5A0000 | i, 0);
    chk("oversize_done", 1, 32'hFFC, 32'h5A5A03FF, 0, 1, 0, 1);
    chk("oversize_w0", 1, 32'h0, 32'h5A5A0000, 0, 1, 0, 0);

    // Reload from RUN: core goes back into reset, fetches read nop until done.
    done_q.push_back(acc_total + 2);
    start(11'd2);
    chk("reload_busy", 1, 32'h0, 32'h0, 1, 0, 1, 0);
    send(32'h11111111, 0);
    start(11'd0);
    chk("start_ignored", 1, 32'h4, 32'h0, 1, 0, 1, 0);
    send(32'h22222222, 0);
    chk("reload_done", 1, 32'h4, 32'h22222222, 0, 0, 0, 1);
    chk("reload_w0", 1, 32'h0, 32'h11111111, 0, 0, 0, 0);
    chk("reload_w2_kept", 1, 32'h8, 32'h5A5A0002, 0, 0, 0, 0);

    fin_vld = 1'b1;
    for (int k = 0; k < 10 && !mon_end; k++) tick();
    if (!mon_end) begin
      $display("FAIL monitor_end: monitor did not finish");
      $fatal(1, "monitor stalled");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Responder end of the core's instruction-fetch port. It holds the instruction memory that `mips_32` reads through `rom_ce_o`, `rom_addr_o` and `rom_data_i`, and serves fetches combinationally. A valid/ready program-load stream writes that memory. The block holds the core in reset through `core_rst_o` until a load completes.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; depth is `DEPTH = 2**ADDR_WIDTH` words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_ce_i`  in  1  fetch enable from the core.
- `rom_addr_i`  in  32  fetch byte address from the core (PC).
- `rom_data_o`  out  32  instruction word returned to the core.
- `load_start_i`  in  1  one-cycle request to begin a program load.
- `load_len_i`  in  ADDR_WIDTH+1  number of words to load; sampled with `load_start_i`.
- `load_valid_i`  in  1  load word is valid.
- `load_data_i`  in  32  load word, already in core byte order.
- `load_ready_o`  out  1  block accepts a load word this cycle.
- `load_done_o`  out  1  one-cycle pulse when the load completes.
- `core_rst_o`  out  1  reset for `mips_32`; high while no valid program is present.
- `err_o`  out  1  sticky fault flag.

## Operation
- **States:** IDLE, LOAD, RUN. `rst` forces IDLE.
- **IDLE:** `core_rst_o`=1, `load_ready_o`=0.
  - `load_start_i` with len=0: go to RUN.
  - `load_start_i` with len>0: go to LOAD; word counter `cnt`=0; `len_q` = min(len, DEPTH).
- **LOAD:** `core_rst_o`=1, `load_ready_o`=1.
  - Each cycle with `load_valid_i`=1 writes `mem[cnt]` ← `load_data_i` and increments `cnt`.
  - When the write with `cnt`=`len_q`-1 is accepted, go to RUN and pulse `load_done_o`.
- **RUN:** `core_rst_o`=0, `load_ready_o`=0.
  - `load_start_i` re-enters LOAD (or stays in RUN if len=0). `core_rst_o` rises again on the same edge.
- **Fetch data:**
  - `rom_data_o` = `mem[rom_addr_i[ADDR_WIDTH+1:2]]` when state=RUN, `rom_ce_i`=1 and the address is legal.
  - Otherwise `rom_data_o` = `ZeroWord` (decodes as nop).
- **Legal address:** `rom_addr_i[1:0]`=0 and `rom_addr_i[31:ADDR_WIDTH+2]`=0.
- **`err_o`:**
  - Set on an edge in RUN where `rom_ce_i`=1 and the address is illegal.
  - Also set when `load_len_i` > DEPTH is sampled; the length is then clamped to DEPTH.
  - Cleared by `rst` or by an accepted `load_start_i`. If both the set and the clear condition hold on the same edge, set wins.
- **`load_start_i` during LOAD:** ignored; the current load continues.
- **`rst` during LOAD:** go to IDLE, `cnt`=0. Memory words already written are retained; memory is never cleared by reset.
- Words beyond `len_q` keep their previous contents.

## Timing
- **Reset values:** state=IDLE, `core_rst_o`=1, `load_ready_o`=0, `load_done_o`=0, `err_o`=0, `cnt`=0. `rom_data_o`=0 because state≠RUN.
- **Fetch latency:** zero. `rom_data_o` is combinational from `rom_addr_i`, `rom_ce_i` and state. The core's IF/ID register captures it on the same edge that advances the PC.
- **Load handshake:** a word transfers on an edge where `load_valid_i` & `load_ready_o`. Throughput is one word per cycle; the sender may hold `load_valid_i` low for any number of cycles.
- **Write timing:** memory write is synchronous. A word written at edge N is readable combinationally after edge N.
- **Completion edge:** on the edge accepting the last word, state→RUN. `load_done_o`=1 and `core_rst_o`=0 during the following cycle, so the core's first fetch (PC 0) occurs in that cycle.
- `load_ready_o` and `rom_data_o` are the only outputs decoded from state; all other outputs are registered.

## Structure
- **Shared `define.v`:**
  - Reuse `ZeroWord`, `InstBus`, `InstAddrBus`.
  - Add `InstMemNumLog2` (default for `ADDR_WIDTH`).
  - Add state encodings `LdIdle`, `LdLoad`, `LdRun`.
- **Sub-module `inst_mem_array`:** DEPTH×32 storage, one synchronous write port, one asynchronous read port.
- **Top-level wiring:** the top level drives `mips_32.rst` from `core_rst_o` OR'd with the system `rst`.

## Test plan
- Reset, then fetch with ce=1 at 0x0 → `rom_data_o`=0, `core_rst_o`=1, `err_o`=0.
- Start with len=4, send 0x20010001, 0x20020002, 0x00221820, 0x00000000 with valid gaps → `load_done_o` pulses once after the 4th accepted word; then 0x8 reads 0x00221820 and 0x4 reads 0x20020002.
- In RUN, fetch 0x2 (misaligned) → `rom_data_o`=0 and `err_o` sets. Separately, fetch 0x1000 with ADDR_WIDTH=10 → same response. A new `load_start_i` clears `err_o`.
- Start with len=3, assert `rst` after 2 words → IDLE, `core_rst_o`=1. A reload with len=0 → RUN; word 0 still holds its first-written value.
- Start with len=1025 → `err_o`=1; after exactly 1024 accepted words `load_done_o` pulses and `load_ready_o` drops.
- In RUN, start with len=2 → `core_rst_o` rises on the next edge, `rom_data_o` reads 0 during LOAD, and fetches resume after `load_done_o`.
